// File: rtl/fp32_div_wb_if.sv
// Request / write-back bundle between the FP issue logic and the FP32 divider.
// The master drives the operation request; the slave returns the register-file write-back.
interface fp32_div_wb_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic [ADDR_W-1:0] rd_in;
    logic              busy;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic [4:0]        fflags;

    modport master (
        output start, op_a, op_b, rd_in,
        input  busy, wb_we, wb_addr, wb_data, fflags
    );

    modport slave (
        input  start, op_a, op_b, rd_in,
        output busy, wb_we, wb_addr, wb_data, fflags
    );
endinterface

// File: rtl/fp32_div_wb.sv
// Iterative radix-2 restoring FP32 divider whose result feeds the FP register file write port.
// RNE rounding only; subnormal inputs and results are flushed to zero.
module fp32_div_wb #(
    parameter int ADDR_W = 5,
    parameter int ITERS  = 26
) (
    input  logic         CLK,
    input  logic         RST,
    fp32_div_wb_if.slave bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, CHECK, DIV, ROUND, WB} state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [31:0]       r_opA;
    logic [31:0]       r_opB;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_wbAddr;
    logic [31:0]       r_wbData;
    logic [4:0]        r_fflags;
    logic [25:0]       r_quo;
    logic [24:0]       r_rem;
    logic signed [9:0] r_exp;
    logic [4:0]        r_count;

    logic              w_sign;
    logic              w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_snanA, w_snanB;
    logic              w_special;
    logic [31:0]       w_specData;
    logic [4:0]        w_specFlags;
    logic [23:0]       w_mantA, w_mantB;
    logic signed [9:0] w_expDiff, w_initExp;
    logic              w_aLess;
    logic [24:0]       w_initRem;
    logic              w_remGe;
    logic [24:0]       w_remNext;
    logic              w_guard, w_sticky, w_roundUp;
    logic [24:0]       w_mantRnd;
    logic [22:0]       w_mantFin;
    logic signed [9:0] w_expFin;
    logic [31:0]       w_rndData;
    logic [4:0]        w_rndFlags;

    // Exponent-zero operands count as signed zero, so no denormal path exists anywhere.
    assign w_sign  = r_opA[31] ^ r_opB[31];
    assign w_zeroA = (r_opA[30:23] == 8'h00);
    assign w_zeroB = (r_opB[30:23] == 8'h00);
    assign w_infA  = (r_opA[30:23] == 8'hFF) && (r_opA[22:0] == 23'd0);
    assign w_infB  = (r_opB[30:23] == 8'hFF) && (r_opB[22:0] == 23'd0);
    assign w_nanA  = (r_opA[30:23] == 8'hFF) && (r_opA[22:0] != 23'd0);
    assign w_nanB  = (r_opB[30:23] == 8'hFF) && (r_opB[22:0] != 23'd0);
    assign w_snanA = w_nanA && !r_opA[22];
    assign w_snanB = w_nanB && !r_opB[22];

    always_comb begin
        w_special   = 1'b1;
        w_specData  = QNAN;
        w_specFlags = 5'b00000;
        if (w_nanA || w_nanB) begin
            w_specFlags = {(w_snanA || w_snanB), 4'b0000};
        end else if ((w_zeroA && w_zeroB) || (w_infA && w_infB)) begin
            w_specFlags = 5'b10000;
        end else if (w_infA) begin
            w_specData = {w_sign, 8'hFF, 23'd0};
        end else if (w_zeroB) begin
            w_specData  = {w_sign, 8'hFF, 23'd0};
            w_specFlags = 5'b01000;
        end else if (w_zeroA || w_infB) begin
            w_specData = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // Pre-normalising the dividend guarantees the first quotient bit is 1.
    assign w_mantA   = {1'b1, r_opA[22:0]};
    assign w_mantB   = {1'b1, r_opB[22:0]};
    assign w_expDiff = $signed({2'b00, r_opA[30:23]}) - $signed({2'b00, r_opB[30:23]}) + 10'sd127;
    assign w_aLess   = (w_mantA < w_mantB);
    assign w_initRem = w_aLess ? {w_mantA, 1'b0} : {1'b0, w_mantA};
    assign w_initExp = w_aLess ? (w_expDiff - 10'sd1) : w_expDiff;

    assign w_remGe   = (r_rem >= {1'b0, w_mantB});
    assign w_remNext = (w_remGe ? (r_rem - {1'b0, w_mantB}) : r_rem) << 1;

    assign w_guard   = r_quo[1];
    assign w_sticky  = r_quo[0] | (r_rem != 25'd0);
    assign w_roundUp = w_guard & (w_sticky | r_quo[2]);
    assign w_mantRnd = {1'b0, r_quo[25:2]} + {24'd0, w_roundUp};
    assign w_mantFin = w_mantRnd[24] ? w_mantRnd[23:1] : w_mantRnd[22:0];
    assign w_expFin  = w_mantRnd[24] ? (r_exp + 10'sd1) : r_exp;

    always_comb begin
        w_rndData  = {w_sign, w_expFin[7:0], w_mantFin};
        w_rndFlags = {4'b0000, (w_guard | w_sticky)};
        if (w_expFin >= 10'sd255) begin
            w_rndData  = {w_sign, 8'hFF, 23'd0};
            w_rndFlags = 5'b00101;
        end else if (w_expFin <= 10'sd0) begin
            w_rndData  = {w_sign, 31'd0};
            w_rndFlags = 5'b00011;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = CHECK;
            CHECK:   w_nextState = w_special ? WB : DIV;
            DIV:     if (r_count == 5'(ITERS - 1)) w_nextState = ROUND;
            ROUND:   w_nextState = WB;
            WB:      w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Write-back registers only change on entry to WB, so the register file never sees partial results.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_opA    <= '0;
            r_opB    <= '0;
            r_rd     <= '0;
            r_wbAddr <= '0;
            r_wbData <= '0;
            r_fflags <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_exp    <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_opA <= bus.op_a;
                        r_opB <= bus.op_b;
                        r_rd  <= bus.rd_in;
                    end
                end
                CHECK: begin
                    if (w_special) begin
                        r_wbData <= w_specData;
                        r_fflags <= w_specFlags;
                        r_wbAddr <= r_rd;
                    end else begin
                        r_rem   <= w_initRem;
                        r_exp   <= w_initExp;
                        r_quo   <= '0;
                        r_count <= '0;
                    end
                end
                DIV: begin
                    r_quo   <= {r_quo[24:0], w_remGe};
                    r_rem   <= w_remNext;
                    r_count <= r_count + 5'd1;
                end
                ROUND: begin
                    r_wbData <= w_rndData;
                    r_fflags <= w_rndFlags;
                    r_wbAddr <= r_rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.wb_we   = (r_state == WB);
    assign bus.wb_addr = r_wbAddr;
    assign bus.wb_data = r_wbData;
    assign bus.fflags  = r_fflags;
endmodule

// File: tb/tb_fp32_div_wb.sv
// Scoreboard bench for fp32_div_wb: expected write-backs are queued at issue time and
// popped by a monitor when wb_we fires, including the exact write-back cycle.
module tb_fp32_div_wb;
    logic CLK;
    logic RST;
    int   cyc;
    int   nChecks;
    int   nFails;
    logic prevWe;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  flags;
        int          cyc;
    } exp_t;

    exp_t sbQ[$];

    fp32_div_wb_if #(.ADDR_W(5)) bus ();

    fp32_div_wb #(.ADDR_W(5), .ITERS(26)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Independent reference: integer long division of the scaled significands.
    function automatic logic [36:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        logic        s, za, zb, ia, ib, na, nb, sna, snb, g, st;
        logic [63:0] ma, mb, q, rem, mant;
        int          e, sh;
        s   = a[31] ^ b[31];
        za  = (a[30:23] == 8'h00);
        zb  = (b[30:23] == 8'h00);
        ia  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        sna = na && !a[22];
        snb = nb && !b[22];
        if (na || nb) return {(sna | snb), 4'b0000, 32'h7FC00000};
        if ((za && zb) || (ia && ib)) return {5'b10000, 32'h7FC00000};
        if (ia) return {5'b00000, s, 8'hFF, 23'd0};
        if (zb) return {5'b01000, s, 8'hFF, 23'd0};
        if (za || ib) return {5'b00000, s, 31'd0};
        ma  = {40'd0, 1'b1, a[22:0]};
        mb  = {40'd0, 1'b1, b[22:0]};
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        q   = (ma << 26) / mb;
        rem = (ma << 26) % mb;
        if (q >= (64'd1 << 26)) begin
            sh = 3;
        end else begin
            sh = 2;
            e  = e - 1;
        end
        mant = q >> sh;
        g    = q[sh-1];
        st   = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0) || (rem != 64'd0);
        if (g && (st || mant[0])) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        if (e <= 0) return {5'b00011, s, 31'd0};
        return {4'b0000, (g | st), s, 8'(e), mant[22:0]};
    endfunction

    // Monitor: every write-back must match the oldest queued expectation, in the expected cycle.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && bus.wb_we) begin
            checkOutput("wb_gap", {31'd0, prevWe}, 32'd0);
            checkOutput("sb_nonempty", {31'd0, (sbQ.size() != 0)}, 32'd1);
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput("wb_data", bus.wb_data, e.data);
                checkOutput("wb_addr", {27'd0, bus.wb_addr}, {27'd0, e.addr});
                checkOutput("fflags", {27'd0, bus.fflags}, {27'd0, e.flags});
                checkOutput("wb_cycle", cyc, e.cyc);
            end
        end
        prevWe <= RST ? bus.wb_we : 1'b0;
    end

    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.rd_in = rd;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge CLK);
        while (bus.busy && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("idle_in_time", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] eData, input logic [4:0] eFlags, input int lat);
        exp_t e;
        startOp(a, b, rd);
        e.addr  = rd;
        e.data  = eData;
        e.flags = eFlags;
        e.cyc   = cyc + lat;
        sbQ.push_back(e);
        waitIdle();
    endtask

    task automatic applyModel(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input int lat);
        logic [36:0] r;
        r = refDiv(a, b);
        applyStimulus(a, b, rd, r[31:0], r[36:32], lat);
    endtask

    initial begin
        logic [31:0] a, b;
        exp_t        e;
        nChecks   = 0;
        nFails    = 0;
        cyc       = 0;
        RST       = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.rd_in = '0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_we", {31'd0, bus.wb_we}, 32'd0);
        checkOutput("rst_addr", {27'd0, bus.wb_addr}, 32'd0);
        checkOutput("rst_data", bus.wb_data, 32'd0);
        checkOutput("rst_flags", {27'd0, bus.fflags}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        applyStimulus(32'h40C00000, 32'h40000000, 5'd5, 32'h40400000, 5'h00, 28);
        applyStimulus(32'h3F800000, 32'h40400000, 5'd7, 32'h3EAAAAAB, 5'h01, 28);
        applyStimulus(32'h3F800000, 32'h00000000, 5'd1, 32'h7F800000, 5'h08, 1);
        applyStimulus(32'h00000000, 32'h00000000, 5'd2, 32'h7FC00000, 5'h10, 1);
        applyStimulus(32'h7F7FFFFF, 32'h3F000000, 5'd3, 32'h7F800000, 5'h05, 28);
        applyStimulus(32'h00800000, 32'h40000000, 5'd4, 32'h00000000, 5'h03, 28);
        applyStimulus(32'h7F800001, 32'h3F800000, 5'd6, 32'h7FC00000, 5'h10, 1);
        applyStimulus(32'h7FC00001, 32'h3F800000, 5'd8, 32'h7FC00000, 5'h00, 1);
        applyStimulus(32'hC0C00000, 32'h40000000, 5'd0, 32'hC0400000, 5'h00, 28);
        applyStimulus(32'hFF800000, 32'h40000000, 5'd9, 32'hFF800000, 5'h00, 1);
        applyStimulus(32'h3F800000, 32'hFF800000, 5'd10, 32'h80000000, 5'h00, 1);
        applyStimulus(32'h7F800000, 32'hFF800000, 5'd11, 32'h7FC00000, 5'h10, 1);
        applyStimulus(32'h00000001, 32'h3F800000, 5'd12, 32'h00000000, 5'h00, 1);
        applyStimulus(32'h3F800000, 32'h80000001, 5'd13, 32'hFF800000, 5'h08, 1);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i < 6) begin
                a[30:23] = 8'($urandom_range(1, 254));
                b[30:23] = 8'($urandom_range(1, 254));
            end else begin
                a[30:23] = 8'($urandom_range(100, 154));
                b[30:23] = 8'($urandom_range(100, 154));
            end
            applyModel(a, b, 5'(i + 14), 28);
        end

        // Start pulses while busy must be dropped without disturbing the running operation.
        startOp(32'h40C00000, 32'h40000000, 5'd30);
        e.addr  = 5'd30;
        e.data  = 32'h40400000;
        e.flags = 5'h00;
        e.cyc   = cyc + 28;
        sbQ.push_back(e);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge CLK);
            startOp(32'h3F800000, 32'h00000000, 5'd31);
        end
        waitIdle();
        repeat (3) @(negedge CLK);
        checkOutput("sb_drained_busy", sbQ.size(), 32'd0);

        // Reset in the middle of DIV: the operation vanishes with no write-back.
        startOp(32'h3F800000, 32'h40400000, 5'd17);
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_we", {31'd0, bus.wb_we}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (35) @(negedge CLK);
        checkOutput("midrst_idle", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_data", bus.wb_data, 32'd0);
        checkOutput("midrst_addr", {27'd0, bus.wb_addr}, 32'd0);

        applyStimulus(32'h3F800000, 32'h40400000, 5'd21, 32'h3EAAAAAB, 5'h01, 28);
        applyModel(32'h42F60000, 32'hC1200000, 5'd22, 28);

        repeat (3) @(negedge CLK);
        checkOutput("sb_drained", sbQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
